// File: rtl/rotary_position_counter_if.sv
// Event inputs and position outputs of the rotary position counter.
interface rotary_position_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             Left;
    logic             Right;
    logic             Clear;
    logic [WIDTH-1:0] Position;
    logic             Changed;
    logic             AtMin;
    logic             AtMax;
    logic             Dir;

    modport master (
        output Left, Right, Clear,
        input  Position, Changed, AtMin, AtMax, Dir
    );

    modport slave (
        input  Left, Right, Clear,
        output Position, Changed, AtMin, AtMax, Dir
    );
endinterface

// File: rtl/rotary_position_counter.sv
// Rotary encoder position counter with wrap/saturate limits.
// Define ROT_ACCEL_EN to enable the fast-rotation step via the interval counter.
module rotary_position_counter #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned MIN_VAL      = 0,
    parameter int unsigned MAX_VAL      = 255,
    parameter int unsigned WRAP         = 1,
    parameter int unsigned ACCEL_CYCLES = 2500000,
    parameter int unsigned ACCEL_STEP   = 4
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    rotary_position_counter_if.slave    bus
);

    localparam int unsigned     AW     = WIDTH + 1;
    localparam logic [AW-1:0]   MIN_W  = AW'(MIN_VAL);
    localparam logic [AW-1:0]   MAX_W  = AW'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_P = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] pos_q, pos_d;
    logic             changed_q, changed_d;
    logic             dir_q, dir_d;
    logic             ev_left, ev_right, ev_any;
    logic [AW-1:0]    step, pos_w, sum_up, floor_dn, nxt_w;

`ifdef ROT_ACCEL_EN
    localparam int unsigned   CW      = $clog2(ACCEL_CYCLES + 1);
    localparam logic [CW-1:0] ACC_MAX = CW'(ACCEL_CYCLES);
    localparam logic [AW-1:0] ASTEP_W = AW'(ACCEL_STEP);

    logic [CW-1:0] ivl_q, ivl_d;

    // Cycles since the last accepted event, saturating at ACCEL_CYCLES
    always_comb begin
        ivl_d = ivl_q;
        if (bus.Clear) begin
            ivl_d = ACC_MAX;
        end else if (ev_any) begin
            ivl_d = '0;
        end else if (ivl_q != ACC_MAX) begin
            ivl_d = ivl_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ivl_q <= ACC_MAX;
        end else begin
            ivl_q <= ivl_d;
        end
    end
`endif

    // Next position: arithmetic one bit wider than Position so limits never overflow
    always_comb begin
        ev_left  = bus.Left & ~bus.Right;
        ev_right = bus.Right & ~bus.Left;
        ev_any   = ev_left | ev_right;
        pos_w    = {1'b0, pos_q};
        step     = AW'(1);
`ifdef ROT_ACCEL_EN
        if (ev_any && (ev_right == dir_q) && (ivl_q < ACC_MAX)) begin
            step = ASTEP_W;
        end
`endif
        sum_up   = pos_w + step;
        floor_dn = MIN_W + step;
        nxt_w    = pos_w;
        if (ev_right) begin
            if (sum_up > MAX_W) begin
                nxt_w = (WRAP != 0) ? (MIN_W + (sum_up - MAX_W - AW'(1))) : MAX_W;
            end else begin
                nxt_w = sum_up;
            end
        end else if (ev_left) begin
            if (pos_w < floor_dn) begin
                nxt_w = (WRAP != 0) ? (MAX_W - (floor_dn - pos_w - AW'(1))) : MIN_W;
            end else begin
                nxt_w = pos_w - step;
            end
        end

        pos_d     = pos_q;
        changed_d = 1'b0;
        dir_d     = dir_q;
        if (bus.Clear) begin
            pos_d     = MIN_P;
            changed_d = (pos_q != MIN_P);
        end else if (ev_any) begin
            pos_d     = WIDTH'(nxt_w);
            changed_d = (pos_d != pos_q);
            dir_d     = ev_right;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pos_q     <= MIN_P;
            changed_q <= 1'b0;
            dir_q     <= 1'b1;
        end else begin
            pos_q     <= pos_d;
            changed_q <= changed_d;
            dir_q     <= dir_d;
        end
    end

    assign bus.Position = pos_q;
    assign bus.Changed  = changed_q;
    assign bus.Dir      = dir_q;
    assign bus.AtMin    = (pos_q == MIN_P);
    assign bus.AtMax    = (pos_q == MAX_P);

endmodule
